// File: rtl/video_fb_line_reader.sv
// Frame-buffer scan-out reader: fetches one frame of pixels over a pipelined Avalon-MM
// read master, buffers them in a show-ahead FIFO and streams them out tagged with sof/eol.
module video_fb_line_reader #(
  parameter int AVS_AW     = 25,
  parameter int AVS_DW     = 16,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int FB_BASE    = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              frame_start,
  output logic [AVS_AW-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [AVS_DW-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [AVS_DW-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sof,
  output logic              src_eol,
  output logic              busy,
  output logic              overrun
);

  localparam int TOTAL = H_DISPLAY * V_DISPLAY;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int SW    = CW + 1;
  localparam int XW    = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
  localparam int YW    = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [IW-1:0]       r_issue_idx;
  logic [IW-1:0]       w_issue_idx_next;
  logic                r_avm_read;
  logic                w_read_next;
  logic [AVS_AW-1:0]   r_avm_address;
  logic [AVS_AW-1:0]   w_addr_next;
  logic [CW-1:0]       r_outstanding;
  logic [CW-1:0]       w_out_next;
  logic [CW-1:0]       r_fifo_count;
  logic [CW-1:0]       w_count_next;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [AVS_DW-1:0]   r_mem [FIFO_DEPTH];
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic                r_overrun;

  logic                w_accept;
  logic                w_last;
  logic                w_start;
  logic                w_src_valid;
  logic                w_pop;
  logic [SW-1:0]       w_used;
  logic                w_credit;

  assign w_accept    = r_avm_read & ~avm_waitrequest;
  assign w_last      = (r_issue_idx == IW'(TOTAL - 1));
  assign w_start     = (r_state == ST_IDLE) & frame_start & enable;
  assign w_src_valid = (r_fifo_count != '0);
  assign w_pop       = w_src_valid & src_ready;

  // A pending (not yet accepted) request already owns one FIFO slot.
  assign w_used   = SW'(r_fifo_count) + SW'(r_outstanding) + SW'(r_avm_read);
  assign w_credit = (w_used < SW'(FIFO_DEPTH));

  assign w_out_next   = r_outstanding + CW'(w_accept) - CW'(avm_readdatavalid);
  assign w_count_next = r_fifo_count + CW'(avm_readdatavalid) - CW'(w_pop);

  always_comb begin
    w_state_next     = r_state;
    w_issue_idx_next = r_issue_idx + IW'(w_accept);
    w_read_next      = r_avm_read;
    w_addr_next      = r_avm_address;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next     = ST_FETCH;
          w_issue_idx_next = '0;
          w_read_next      = 1'b1;
          w_addr_next      = AVS_AW'(FB_BASE);
        end
      end
      ST_FETCH: begin
        if (w_accept && w_last) begin
          w_state_next = ST_DRAIN;
          w_read_next  = 1'b0;
        end else if (!r_avm_read || w_accept) begin
          // Only a free request slot is subject to the credit check; a stalled one is held.
          w_read_next = w_credit;
          w_addr_next = AVS_AW'(FB_BASE) + AVS_AW'(w_issue_idx_next);
        end
      end
      ST_DRAIN: begin
        w_read_next = 1'b0;
        if (w_out_next == '0 && w_count_next == '0) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_read_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= ST_IDLE;
      r_issue_idx   <= '0;
      r_avm_read    <= 1'b0;
      r_avm_address <= '0;
      r_outstanding <= '0;
      r_fifo_count  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_issue_idx   <= w_issue_idx_next;
      r_avm_read    <= w_read_next;
      r_avm_address <= w_addr_next;
      r_outstanding <= w_out_next;
      r_fifo_count  <= w_count_next;
      r_overrun     <= frame_start & (r_state != ST_IDLE);
      if (avm_readdatavalid) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_pop) begin
        if (r_x == XW'(H_DISPLAY - 1)) begin
          r_x <= '0;
          r_y <= (r_y == YW'(V_DISPLAY - 1)) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge sys_clk) begin
    if (avm_readdatavalid) begin
      r_mem[r_wr_ptr] <= avm_readdata;
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign src_valid   = w_src_valid;
  assign src_data    = w_src_valid ? r_mem[r_rd_ptr] : '0;
  assign src_sof     = w_src_valid & (r_x == '0) & (r_y == '0);
  assign src_eol     = w_src_valid & (r_x == XW'(H_DISPLAY - 1));
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = r_overrun;

  a_no_fifo_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    !(avm_readdatavalid && !w_pop && r_fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_video_fb_line_reader.sv
// Directed bench for video_fb_line_reader: 4x2 frame, 4-deep FIFO, 2-cycle-latency slave.
module tb_video_fb_line_reader;

  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int BASE  = 'h100;
  localparam int DEPTH = 4;
  localparam int NPIX  = H * V;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          enable;
  logic          frame_start;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          src_sof;
  logic          src_eol;
  logic          busy;
  logic          overrun;

  logic src_ready_man, rnd_mode, wait102, rnd_ready, rnd_wait;
  int   w102_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  video_fb_line_reader #(
    .AVS_AW(AW), .AVS_DW(DW), .H_DISPLAY(H), .V_DISPLAY(V),
    .FB_BASE(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .frame_start(frame_start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sof(src_sof), .src_eol(src_eol), .busy(busy), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return (DW'(a) * 16'h03B1) ^ 16'hC35A;
  endfunction

  assign src_ready = rnd_mode ? rnd_ready : src_ready_man;
  assign avm_waitrequest = (wait102 && avm_read && avm_address == AW'(BASE + 2) && w102_cnt < 3)
                           || (rnd_mode && rnd_wait);

  always @(posedge sys_clk) begin
    rnd_ready <= ($urandom_range(0, 2) != 0);
    rnd_wait  <= ($urandom_range(0, 3) == 0);
  end

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      w102_cnt <= 0;
    end else if (wait102 && avm_read && avm_address == AW'(BASE + 2) && w102_cnt < 3) begin
      w102_cnt <= w102_cnt + 1;
    end
  end

  // Slave memory: data appears two cycles after the accepting edge, in order.
  logic          p1_v;
  logic [DW-1:0] p1_d;
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p1_v              <= 1'b0;
      p1_d              <= '0;
      avm_readdatavalid <= 1'b0;
      avm_readdata      <= '0;
    end else begin
      p1_v              <= avm_read && !avm_waitrequest;
      p1_d              <= memfn(avm_address);
      avm_readdatavalid <= p1_v;
      avm_readdata      <= p1_d;
    end
  end

  // Monitor on the falling edge: logs pops, accepts, stalls and overrun pulses.
  logic [DW-1:0] pix_q[$];
  logic          sof_q[$];
  logic          eol_q[$];
  logic [AW-1:0] addr_q[$];
  int pix_cnt = 0, acc_cnt = 0, sof_cnt = 0, eol_cnt = 0, ovr_cnt = 0;
  int stab_viol = 0, stall_cnt = 0, max_infl = 0, infl_base = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge sys_clk) begin
    if (sys_rst) begin
      prev_stall = 1'b0;
      infl_base  = acc_cnt - pix_cnt;
    end else begin
      if (src_valid && src_ready) begin
        pix_q.push_back(src_data);
        sof_q.push_back(src_sof);
        eol_q.push_back(src_eol);
        if (src_sof) sof_cnt++;
        if (src_eol) eol_cnt++;
        $display("pixel %0d data=%h sof=%0d eol=%0d", pix_cnt, src_data, src_sof, src_eol);
        pix_cnt++;
      end
      if (avm_read && !avm_waitrequest) begin
        addr_q.push_back(avm_address);
        acc_cnt++;
      end
      if (avm_read && avm_waitrequest) stall_cnt++;
      if (prev_stall && (!avm_read || avm_address != prev_addr)) stab_viol++;
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      if (overrun) ovr_cnt++;
      if (acc_cnt - pix_cnt - infl_base > max_infl) max_infl = acc_cnt - pix_cnt - infl_base;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'(0));
  endtask

  task automatic check_frame(input string tag, input int bp, input int ba);
    chk({tag, "_npix"}, 32'(pix_cnt - bp), 32'(NPIX));
    chk({tag, "_nacc"}, 32'(acc_cnt - ba), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      if (bp + i < pix_q.size()) begin
        chk($sformatf("%s_pix%0d", tag, i), 32'(pix_q[bp + i]), 32'(memfn(AW'(BASE + i))));
        chk($sformatf("%s_tag%0d", tag, i), 32'({sof_q[bp + i], eol_q[bp + i]}),
            32'({i == 0, (i % H) == H - 1}));
      end
      if (ba + i < addr_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(addr_q[ba + i]), 32'(BASE + i));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp, ba, bs, bo, be, n;
    sys_rst = 1'b1; enable = 1'b1; frame_start = 1'b0;
    src_ready_man = 1'b1; rnd_mode = 1'b0; wait102 = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(src_valid), 32'(0));
    chk("rst_read", 32'(avm_read), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sof", 32'(src_sof), 32'(0));
    sys_rst = 1'b0;
    tick();

    // frame_start while disabled is ignored
    enable = 1'b0;
    pulse_start();
    enable = 1'b1;
    tick();
    chk("dis_busy", 32'(busy), 32'(0));
    chk("dis_ovr", 32'(ovr_cnt), 32'(0));
    chk("dis_acc", 32'(acc_cnt), 32'(0));

    // Basic frame, ready always high; first pixel 2 + 2 cycles after frame_start
    bp = pix_cnt; ba = acc_cnt;
    pulse_start();
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_read", 32'(avm_read), 32'(1));
    chk("t1_addr0", 32'(avm_address), 32'(BASE));
    tick(); tick();
    chk("t1_lat_early", 32'(src_valid), 32'(0));
    tick();
    chk("t1_lat", 32'(src_valid), 32'(1));
    chk("t1_head", 32'(src_data), 32'(memfn(AW'(BASE))));
    chk("t1_head_sof", 32'(src_sof), 32'(1));
    wait_idle("t1_idle", 200);
    check_frame("t1", bp, ba);
    chk("t1_valid_after", 32'(src_valid), 32'(0));

    // Back-pressure: credit limits in-flight reads to the FIFO depth
    bp = pix_cnt; ba = acc_cnt;
    src_ready_man = 1'b0;
    pulse_start();
    repeat (20) tick();
    chk("t2_acc4", 32'(acc_cnt - ba), 32'(DEPTH));
    chk("t2_read_low", 32'(avm_read), 32'(0));
    chk("t2_hold_valid", 32'(src_valid), 32'(1));
    chk("t2_hold_data", 32'(src_data), 32'(memfn(AW'(BASE))));
    src_ready_man = 1'b1;
    wait_idle("t2_idle", 200);
    check_frame("t2", bp, ba);
    chk("t2_infl", 32'(max_infl <= DEPTH), 32'(1));

    // Three wait-state cycles on address BASE+2
    bp = pix_cnt; ba = acc_cnt; bs = stall_cnt;
    wait102 = 1'b1;
    pulse_start();
    wait_idle("t3_idle", 200);
    wait102 = 1'b0;
    check_frame("t3", bp, ba);
    chk("t3_stalls", 32'(stall_cnt - bs), 32'(3));
    chk("t3_stable", 32'(stab_viol), 32'(0));

    // frame_start while busy: one overrun pulse, frame unaffected
    bp = pix_cnt; ba = acc_cnt; bo = ovr_cnt;
    pulse_start();
    tick(); tick();
    frame_start = 1'b1;
    tick();
    chk("t4_ovr_hi", 32'(overrun), 32'(1));
    frame_start = 1'b0;
    tick();
    chk("t4_ovr_lo", 32'(overrun), 32'(0));
    chk("t4_busy", 32'(busy), 32'(1));
    wait_idle("t4_idle", 200);
    check_frame("t4", bp, ba);
    chk("t4_ovr_cnt", 32'(ovr_cnt - bo), 32'(1));

    // Asynchronous reset after the fifth pixel, then a clean frame
    bp = pix_cnt;
    pulse_start();
    n = 0;
    while (pix_cnt - bp < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reach5", 32'(pix_cnt - bp >= 5), 32'(1));
    #2 sys_rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(src_valid), 32'(0));
    chk("t5_rst_data", 32'(src_data), 32'(0));
    chk("t5_rst_read", 32'(avm_read), 32'(0));
    chk("t5_rst_addr", 32'(avm_address), 32'(0));
    chk("t5_rst_busy", 32'(busy), 32'(0));
    chk("t5_rst_tags", 32'({src_sof, src_eol, overrun}), 32'(0));
    tick();
    sys_rst = 1'b0;
    tick();
    bp = pix_cnt; ba = acc_cnt;
    pulse_start();
    wait_idle("t5_idle", 200);
    check_frame("t5b", bp, ba);

    // Random ready and waitrequest across three frames
    bp = pix_cnt; ba = acc_cnt; bs = sof_cnt; be = eol_cnt;
    rnd_mode = 1'b1;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      wait_idle($sformatf("t6_idle%0d", f), 1000);
    end
    rnd_mode = 1'b0;
    chk("t6_npix", 32'(pix_cnt - bp), 32'(3 * NPIX));
    chk("t6_nacc", 32'(acc_cnt - ba), 32'(3 * NPIX));
    for (int i = 0; i < 3 * NPIX; i++) begin
      if (bp + i < pix_q.size()) begin
        chk($sformatf("t6_pix%0d", i), 32'(pix_q[bp + i]), 32'(memfn(AW'(BASE + (i % NPIX)))));
      end
    end
    chk("t6_sof", 32'(sof_cnt - bs), 32'(3));
    chk("t6_eol", 32'(eol_cnt - be), 32'(3 * V));
    chk("t6_stable", 32'(stab_viol), 32'(0));
    chk("t6_infl", 32'(max_infl <= DEPTH), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
